// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Program-counter and instruction-fetch sequencer at the consumer end of the
//   branch interface. It owns the PC, issues word fetches to instruction
//   memory under a ready handshake, holds the fetched word for decode, and on
//   a redirect from the branch unit jumps to the new target and squashes the
//   wrong-path pipeline for FLUSH_CYCLES cycles.
//
//   Parameters
//     RESET_VECTOR  first fetch address after reset
//     PC_INCREMENT  byte step between sequential fetches (power of 2)
//     FLUSH_CYCLES  bubble cycles after a redirect (1..7)
//
//   Ports
//     ClockInput        in   1   rising-edge clock
//     ResetInput        in   1   asynchronous active-low reset
//     BranchSignal      in   1   redirect request, sampled every cycle
//     BranchAddress     in   32  redirect target, valid with BranchSignal
//     StallInput        in   1   decode hazard, hold current instruction
//     MemReady          in   1   InstructionIn is valid this cycle
//     InstructionIn     in   32  fetched word
//     FetchAddress      out  32  address presented to instruction memory
//     FetchRequest      out  1   fetch strobe, FetchAddress valid while high
//     PCAddress         out  32  address of InstructionOut
//     InstructionOut    out  32  instruction held for decode
//     InstructionValid  out  1   InstructionOut is on the correct path
//     FlushSignal       out  1   squash indication to decode/execute
//     MisalignFault     out  1   one-cycle pulse on a misaligned branch target
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_INCREMENT = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        ClockInput,
  input  logic        ResetInput,
  input  logic        BranchSignal,
  input  logic [31:0] BranchAddress,
  input  logic        StallInput,
  input  logic        MemReady,
  input  logic [31:0] InstructionIn,
  output logic [31:0] FetchAddress,
  output logic        FetchRequest,
  output logic [31:0] PCAddress,
  output logic [31:0] InstructionOut,
  output logic        InstructionValid,
  output logic        FlushSignal,
  output logic        MisalignFault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [31:0] INCREMENT  = 32'(PC_INCREMENT);
  // Byte-offset bits below the fetch granule; a redirect clears them.
  localparam logic [31:0] LOW_MASK   = INCREMENT - 32'd1;
  // The count is loaded with one less than the bubble length because the
  // cycle that reaches zero is itself still a flush cycle.
  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_r;
  state_t      nextState_s;
  logic [2:0]  flushCount_r;
  logic [2:0]  nextFlushCount_s;
  logic [31:0] nextFetchAddress_s;
  logic [31:0] nextPc_s;
  logic [31:0] nextInstruction_s;
  logic        nextValid_s;
  logic        nextMisalign_s;
  logic        redirect_s;

  // A redirect is honoured in every state except the single boot cycle.
  assign redirect_s = BranchSignal && (state_r != BOOT);

  // Next-state and next-output computation; redirect outranks stall and ready.
  always_comb begin
    nextState_s        = state_r;
    nextFlushCount_s   = flushCount_r;
    nextFetchAddress_s = FetchAddress;
    nextPc_s           = PCAddress;
    nextInstruction_s  = InstructionOut;
    nextValid_s        = InstructionValid;
    nextMisalign_s     = 1'b0;

    if (redirect_s) begin
      // Any memory return in this cycle is dropped with the wrong path.
      nextFetchAddress_s = BranchAddress & ~LOW_MASK;
      nextMisalign_s     = |(BranchAddress & LOW_MASK);
      nextValid_s        = 1'b0;
      nextFlushCount_s   = FLUSH_LOAD;
      nextState_s        = FLUSH;
    end else begin
      case (state_r)
        BOOT: begin
          nextState_s = FETCH;
        end
        FETCH: begin
          if (MemReady) begin
            if (StallInput) begin
              // Leave FetchAddress alone so the same word is fetched again.
              nextState_s = HOLD;
            end else begin
              nextInstruction_s  = InstructionIn;
              nextPc_s           = FetchAddress;
              nextValid_s        = 1'b1;
              nextFetchAddress_s = FetchAddress + INCREMENT;
              nextState_s        = FETCH;
            end
          end else begin
            // Wait state: memory has not answered yet.
            nextState_s = FETCH;
          end
        end
        HOLD: begin
          if (StallInput) begin
            nextState_s = HOLD;
          end else begin
            nextState_s = FETCH;
          end
        end
        FLUSH: begin
          nextValid_s = 1'b0;
          if (flushCount_r == 3'd0) begin
            nextState_s = FETCH;
          end else begin
            nextFlushCount_s = flushCount_r - 3'd1;
            nextState_s      = FLUSH;
          end
        end
        default: begin
          nextState_s = BOOT;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge ClockInput or negedge ResetInput) begin
    if (!ResetInput) begin
      state_r          <= BOOT;
      flushCount_r     <= 3'd0;
      FetchAddress     <= RESET_VECTOR;
      FetchRequest     <= 1'b0;
      PCAddress        <= 32'h0000_0000;
      InstructionOut   <= 32'h0000_0000;
      InstructionValid <= 1'b0;
      FlushSignal      <= 1'b0;
      MisalignFault    <= 1'b0;
    end else begin
      state_r          <= nextState_s;
      flushCount_r     <= nextFlushCount_s;
      FetchAddress     <= nextFetchAddress_s;
      FetchRequest     <= (nextState_s == FETCH);
      PCAddress        <= nextPc_s;
      InstructionOut   <= nextInstruction_s;
      InstructionValid <= nextValid_s;
      FlushSignal      <= (nextState_s == FLUSH);
      MisalignFault    <= nextMisalign_s;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer. A behavioural model tracks the
//   fetch pointer, the last accepted word, the remaining bubble count and the
//   stall condition; a compare process checks every DUT output against it on
//   each falling edge. Directed sequences pin the model with literal values,
//   then a randomized phase exercises stalls, wait states, redirects, wrap
//   and asynchronous resets.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] INC = 32'd4;
  localparam int          FC  = 2;

  logic        ClockInput    = 1'b0;
  logic        ResetInput    = 1'b0;
  logic        BranchSignal  = 1'b0;
  logic [31:0] BranchAddress = 32'h0;
  logic        StallInput    = 1'b0;
  logic        MemReady      = 1'b0;
  logic [31:0] InstructionIn = 32'h0;
  logic [31:0] FetchAddress;
  logic        FetchRequest;
  logic [31:0] PCAddress;
  logic [31:0] InstructionOut;
  logic        InstructionValid;
  logic        FlushSignal;
  logic        MisalignFault;

  int testsRun    = 0;
  int testsFailed = 0;

  fetch_sequencer #(
    .RESET_VECTOR(RV),
    .PC_INCREMENT(4),
    .FLUSH_CYCLES(FC)
  ) dut (
    .ClockInput      (ClockInput),
    .ResetInput      (ResetInput),
    .BranchSignal    (BranchSignal),
    .BranchAddress   (BranchAddress),
    .StallInput      (StallInput),
    .MemReady        (MemReady),
    .InstructionIn   (InstructionIn),
    .FetchAddress    (FetchAddress),
    .FetchRequest    (FetchRequest),
    .PCAddress       (PCAddress),
    .InstructionOut  (InstructionOut),
    .InstructionValid(InstructionValid),
    .FlushSignal     (FlushSignal),
    .MisalignFault   (MisalignFault)
  );

  always #5 ClockInput = ~ClockInput;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Behavioural model state.
  logic        mBoot;
  logic        mHolding;
  int          mFlushLeft;
  logic [31:0] mAddr;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic        mValid;
  logic        mMis;

  // Reference model: one update per rising edge from the applied inputs.
  always @(posedge ClockInput or negedge ResetInput) begin
    if (!ResetInput) begin
      mBoot      <= 1'b1;
      mHolding   <= 1'b0;
      mFlushLeft <= 0;
      mAddr      <= RV;
      mPc        <= 32'h0;
      mInstr     <= 32'h0;
      mValid     <= 1'b0;
      mMis       <= 1'b0;
    end else begin
      mMis <= 1'b0;
      if (mBoot) begin
        mBoot <= 1'b0;
      end else if (BranchSignal) begin
        mAddr      <= BranchAddress - (BranchAddress % INC);
        mMis       <= (BranchAddress % INC) != 32'd0;
        mValid     <= 1'b0;
        mFlushLeft <= FC;
        mHolding   <= 1'b0;
      end else if (mFlushLeft > 0) begin
        mFlushLeft <= mFlushLeft - 1;
      end else if (mHolding) begin
        mHolding <= StallInput;
      end else if (MemReady && !StallInput) begin
        mInstr <= InstructionIn;
        mPc    <= mAddr;
        mValid <= 1'b1;
        mAddr  <= mAddr + INC;
      end else if (MemReady) begin
        mHolding <= 1'b1;
      end else begin
        mHolding <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge ClockInput) begin
    check ("FetchAddress",     FetchAddress,     mAddr);
    check1("FetchRequest",     FetchRequest,     !mBoot && !mHolding && (mFlushLeft == 0));
    check ("PCAddress",        PCAddress,        mPc);
    check ("InstructionOut",   InstructionOut,   mInstr);
    check1("InstructionValid", InstructionValid, mValid);
    check1("FlushSignal",      FlushSignal,      mFlushLeft != 0);
    check1("MisalignFault",    MisalignFault,    mMis);
  end

  task automatic step();
    @(posedge ClockInput);
    @(negedge ClockInput);
    InstructionIn = $urandom;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge ClockInput);
    check ("rst FetchAddress", FetchAddress, RV);
    check1("rst FetchRequest", FetchRequest, 1'b0);
    check ("rst PCAddress", PCAddress, 32'h0);
    check1("rst InstructionValid", InstructionValid, 1'b0);
    check1("rst FlushSignal", FlushSignal, 1'b0);

    // Sequential fetch from reset, memory always ready
    MemReady      = 1'b1;
    InstructionIn = $urandom;
    ResetInput    = 1'b1;
    step();
    step();
    check1("seq valid cycle3", InstructionValid, 1'b1);
    check ("seq pc cycle3", PCAddress, 32'h0);
    check ("seq fa cycle3", FetchAddress, 32'h4);
    step();
    check ("seq fa 8", FetchAddress, 32'h8);

    // Three wait states at address 8
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check ("wait fa", FetchAddress, 32'h8);
      check1("wait req", FetchRequest, 1'b1);
    end
    MemReady      = 1'b1;
    InstructionIn = 32'hA5A5_0008;
    @(posedge ClockInput);
    @(negedge ClockInput);
    check ("wait capture pc", PCAddress, 32'h8);
    check ("wait capture instr", InstructionOut, 32'hA5A5_0008);

    // Stall two cycles at address 12
    StallInput = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check1("stall req", FetchRequest, 1'b0);
      check ("stall instr", InstructionOut, 32'hA5A5_0008);
      check ("stall fa", FetchAddress, 32'hC);
    end
    StallInput = 1'b0;
    step();
    check1("unstall req", FetchRequest, 1'b1);
    step();
    check ("refetch pc", PCAddress, 32'hC);
    check ("refetch fa", FetchAddress, 32'h10);

    // Aligned redirect to 0x100
    BranchSignal  = 1'b1;
    BranchAddress = 32'h0000_0100;
    step();
    BranchSignal = 1'b0;
    check1("br flush1", FlushSignal, 1'b1);
    check1("br valid", InstructionValid, 1'b0);
    check ("br fa", FetchAddress, 32'h100);
    check1("br req", FetchRequest, 1'b0);
    step();
    check1("br flush2", FlushSignal, 1'b1);
    step();
    check1("br flush end", FlushSignal, 1'b0);
    check1("br req rise", FetchRequest, 1'b1);
    step();
    check ("br pc", PCAddress, 32'h100);
    check1("br valid again", InstructionValid, 1'b1);

    // Misaligned redirect while stalled
    StallInput    = 1'b1;
    BranchSignal  = 1'b1;
    BranchAddress = 32'h0000_0103;
    step();
    BranchSignal = 1'b0;
    StallInput   = 1'b0;
    check1("mis pulse", MisalignFault, 1'b1);
    check ("mis fa", FetchAddress, 32'h100);
    check1("mis flush", FlushSignal, 1'b1);
    step();
    check1("mis pulse end", MisalignFault, 1'b0);
    step();
    step();
    check ("mis pc", PCAddress, 32'h100);

    // Second redirect mid-flush, then reset mid-flush
    BranchSignal  = 1'b1;
    BranchAddress = 32'h0000_0100;
    step();
    BranchAddress = 32'h0000_0200;
    step();
    BranchSignal = 1'b0;
    check ("rebranch fa", FetchAddress, 32'h200);
    check1("rebranch flush", FlushSignal, 1'b1);
    step();
    check1("rebranch flush2", FlushSignal, 1'b1);
    #2 ResetInput = 1'b0;
    @(negedge ClockInput);
    check ("midflush rst fa", FetchAddress, RV);
    check1("midflush rst flush", FlushSignal, 1'b0);
    check1("midflush rst req", FetchRequest, 1'b0);
    #2 ResetInput = 1'b1;
    step();
    step();

    // Fetch address wraps past the top of the address space
    BranchSignal  = 1'b1;
    BranchAddress = 32'hFFFF_FFFC;
    step();
    BranchSignal = 1'b0;
    step();
    step();
    step();
    check ("wrap pc", PCAddress, 32'hFFFF_FFFC);
    check ("wrap fa", FetchAddress, 32'h0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      MemReady     = ($urandom_range(0, 9) < 7);
      StallInput   = ($urandom_range(0, 9) < 2);
      BranchSignal = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       BranchAddress = $urandom;
        1:       BranchAddress = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: BranchAddress = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 63) * 4);
      endcase
      if ($urandom_range(0, 399) == 0) begin
        #2 ResetInput = 1'b0;
        @(negedge ClockInput);
        #2 ResetInput = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
